// File: rtl/m_carry_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : m_carry_scheduler
// Description : Sequences one stream pass through an OR-with-carry stage.
//               Each RUN cycle samples the stage's OR output and its
//               thermometer carry vector. Carries that the OR output could
//               not represent are banked in a pending counter. They are
//               re-injected into later idle slots, and any remainder is
//               flushed in a DRAIN phase so that no high input is lost.
// Ports       : CLK        clock, rising edge
//               RST_N      synchronous active-low reset
//               START      begin a pass (accepted only in IDLE)
//               LEN        number of stream cycles, captured with START
//               OR_IN      OR output of the controlled stage
//               CARRY_IN   thermometer carry from the controlled stage
//               IN_EN      stage enable, high only in RUN
//               OUT        registered, carry-compensated stream bit
//               OUT_VALID  registered qualifier for OUT
//               BUSY       high in RUN, DRAIN and DONE
//               DONE       one-cycle end-of-pass pulse
//               OVF        sticky pending-counter saturation flag
//               PEND       current pending-carry count
// Revision    : 1.0  initial release
// ============================================================================
module m_carry_scheduler #(
    parameter int N       = 3,
    parameter int N_CARRY = 2,
    parameter int ACC_W   = 4,
    parameter int LEN_W   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [LEN_W-1:0]   LEN,
    input  logic               OR_IN,
    input  logic [N_CARRY-1:0] CARRY_IN,
    output logic               IN_EN,
    output logic               OUT,
    output logic               OUT_VALID,
    output logic               BUSY,
    output logic               DONE,
    output logic               OVF,
    output logic [ACC_W-1:0]   PEND
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    // Wide enough for the unsaturated pend + carry sum, so that an
    // overflow can be detected before clamping.
    localparam int SUM_W = ACC_W + $clog2(N + N_CARRY + 1) + 1;
    localparam logic [ACC_W-1:0] c_PEND_MAX = '1;

    logic [1:0]       r_state_q, w_state_d;
    logic [LEN_W-1:0] r_cnt_q,   w_cnt_d;
    logic [ACC_W-1:0] r_pend_q,  w_pend_d;
    logic             r_ovf_q,   w_ovf_d;
    logic             r_out_q,   w_out_d;
    logic             r_valid_q, w_valid_d;

    logic [SUM_W-1:0] w_c;
    logic [SUM_W-1:0] w_true;
    logic             w_dec;
    logic             w_sat;

    // Carry popcount. The thermometer form is deliberately not enforced:
    // every set bit counts as one extra high input.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < N_CARRY; k++) begin
            w_c = w_c + SUM_W'(CARRY_IN[k]);
        end
    end

    // Re-inject one banked carry whenever the stage's own OR output is low.
    assign w_dec  = !OR_IN && (r_pend_q != '0);
    assign w_true = SUM_W'(r_pend_q) + w_c - SUM_W'(w_dec);
    assign w_sat  = (w_true > SUM_W'(c_PEND_MAX));

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_pend_d  = r_pend_q;
        w_ovf_d   = r_ovf_q;
        w_out_d   = 1'b0;
        w_valid_d = 1'b0;
        case (r_state_q)
            c_S_IDLE: begin
                if (START) begin
                    w_cnt_d   = LEN;
                    w_pend_d  = '0;
                    w_ovf_d   = 1'b0;
                    w_state_d = (LEN != '0) ? c_S_RUN : c_S_DONE;
                end
            end
            c_S_RUN: begin
                w_out_d   = OR_IN | (r_pend_q != '0);
                w_valid_d = 1'b1;
                w_pend_d  = w_sat ? c_PEND_MAX : w_true[ACC_W-1:0];
                w_ovf_d   = r_ovf_q | w_sat;
                w_cnt_d   = r_cnt_q - LEN_W'(1);
                if (r_cnt_q == LEN_W'(1)) begin
                    w_state_d = (w_pend_d != '0) ? c_S_DRAIN : c_S_DONE;
                end
            end
            c_S_DRAIN: begin
                w_out_d   = 1'b1;
                w_valid_d = 1'b1;
                w_pend_d  = r_pend_q - ACC_W'(1);
                // <= 1 rather than == 1 so a zero count can never wrap.
                if (r_pend_q <= ACC_W'(1)) begin
                    w_pend_d  = '0;
                    w_state_d = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_d = c_S_IDLE;
            end
            default: begin
                w_state_d = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state_q <= c_S_IDLE;
            r_cnt_q   <= '0;
            r_pend_q  <= '0;
            r_ovf_q   <= 1'b0;
            r_out_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_pend_q  <= w_pend_d;
            r_ovf_q   <= w_ovf_d;
            r_out_q   <= w_out_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign IN_EN     = (r_state_q == c_S_RUN);
    assign BUSY      = (r_state_q != c_S_IDLE);
    assign DONE      = (r_state_q == c_S_DONE);
    assign OUT       = r_out_q;
    assign OUT_VALID = r_valid_q;
    assign OVF       = r_ovf_q;
    assign PEND      = r_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_m_carry_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_carry_scheduler
// Description : Directed self-checking bench for m_carry_scheduler.
// Revision    : 1.0  initial release
// ============================================================================
module tb_m_carry_scheduler;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] LEN;
    logic        OR_IN;
    logic [1:0]  CARRY_IN;
    logic        IN_EN;
    logic        OUT;
    logic        OUT_VALID;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [3:0]  PEND;

    int n_checks;
    int n_pass;
    int n_fail;

    m_carry_scheduler #(
        .N       (3),
        .N_CARRY (2),
        .ACC_W   (4),
        .LEN_W   (16)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .LEN       (LEN),
        .OR_IN     (OR_IN),
        .CARRY_IN  (CARRY_IN),
        .IN_EN     (IN_EN),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVF       (OVF),
        .PEND      (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock and settle past the edge before sampling/driving.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int ones;
        int ticks;
        int exp_p;
        logic seen;

        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        RST_N    = 1'b0;
        START    = 1'b1;
        LEN      = 16'd5;
        OR_IN    = 1'b0;
        CARRY_IN = 2'b00;

        // Reset held with START asserted: nothing may start.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_en", 32'(IN_EN), 0);
            chk("rst_busy",  32'(BUSY), 0);
            chk("rst_valid", 32'(OUT_VALID), 0);
            chk("rst_out",   32'(OUT), 0);
            chk("rst_done",  32'(DONE), 0);
            chk("rst_ovf",   32'(OVF), 0);
            chk("rst_pend",  32'(PEND), 0);
        end
        RST_N = 1'b1;
        START = 1'b0;
        tick();
        chk("idle_busy", 32'(BUSY), 0);

        // LEN=4, OR=1, carry=01 every cycle: 4 run ones + 4 drain ones.
        LEN = 16'd4; OR_IN = 1'b1; CARRY_IN = 2'b01; START = 1'b1;
        tick();
        START = 1'b0;
        LEN   = 16'd9;
        chk("p1_in_en_first", 32'(IN_EN), 1);
        chk("p1_valid_first", 32'(OUT_VALID), 0);
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (OUT && OUT_VALID) ones++;
            chk("p1_run_out",   32'(OUT), 1);
            chk("p1_run_valid", 32'(OUT_VALID), 1);
            chk("p1_run_pend",  32'(PEND), 32'(i + 1));
            chk("p1_run_in_en", 32'(IN_EN), (i < 3) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (OUT && OUT_VALID) ones++;
            chk("p1_drain_out",  32'(OUT), 1);
            chk("p1_drain_pend", 32'(PEND), 32'(3 - i));
            chk("p1_drain_done", 32'(DONE), (i == 3) ? 1 : 0);
        end
        chk("p1_total_ones", 32'(ones), 8);
        tick();
        chk("p1_done_pulse", 32'(DONE), 0);
        chk("p1_idle_valid", 32'(OUT_VALID), 0);
        chk("p1_idle_busy",  32'(BUSY), 0);

        // LEN=3, samples (1,11),(0,00),(0,00): banked carries fill the gaps.
        LEN = 16'd3; OR_IN = 1'b1; CARRY_IN = 2'b11; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("p2_s1_out",  32'(OUT), 1);
        chk("p2_s1_pend", 32'(PEND), 2);
        OR_IN = 1'b0; CARRY_IN = 2'b00;
        tick();
        chk("p2_s2_out",  32'(OUT), 1);
        chk("p2_s2_pend", 32'(PEND), 1);
        tick();
        chk("p2_s3_out",  32'(OUT), 1);
        chk("p2_s3_pend", 32'(PEND), 0);
        chk("p2_s3_done", 32'(DONE), 1);
        chk("p2_s3_in_en", 32'(IN_EN), 0);
        tick();
        chk("p2_idle_valid", 32'(OUT_VALID), 0);

        // LEN=10, OR=1, carry=11: saturation at 15 from the 8th sample.
        LEN = 16'd10; OR_IN = 1'b1; CARRY_IN = 2'b11; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_p = (2 * (i + 1) > 15) ? 15 : 2 * (i + 1);
            chk("p3_run_pend", 32'(PEND), 32'(exp_p));
            chk("p3_run_ovf",  32'(OVF), (i >= 7) ? 1 : 0);
        end
        ones  = 0;
        ticks = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            ticks++;
            if (OUT && OUT_VALID) ones++;
            if (DONE) seen = 1'b1;
        end
        chk("p3_done_seen",   32'(seen), 1);
        chk("p3_drain_ticks", 32'(ticks), 15);
        chk("p3_drain_ones",  32'(ones), 15);
        tick();
        chk("p3_ovf_sticky", 32'(OVF), 1);
        chk("p3_pend_hold",  32'(PEND), 0);

        // LEN=0: DONE immediately, no RUN, OVF cleared by the new START.
        LEN = 16'd0; START = 1'b1;
        tick();
        START = 1'b0;
        chk("p4_done",  32'(DONE), 1);
        chk("p4_in_en", 32'(IN_EN), 0);
        chk("p4_valid", 32'(OUT_VALID), 0);
        chk("p4_ovf",   32'(OVF), 0);
        tick();
        chk("p4_done_end", 32'(DONE), 0);
        chk("p4_valid2",   32'(OUT_VALID), 0);
        chk("p4_busy",     32'(BUSY), 0);

        // START held during RUN is ignored; reset mid-RUN aborts silently.
        LEN = 16'd5; OR_IN = 1'b0; CARRY_IN = 2'b01; START = 1'b1;
        tick();
        LEN = 16'd2;
        tick();
        chk("p5_s1_out",  32'(OUT), 0);
        chk("p5_s1_pend", 32'(PEND), 1);
        tick();
        chk("p5_s2_out",  32'(OUT), 1);
        chk("p5_s2_pend", 32'(PEND), 1);
        START = 1'b0;
        tick();
        chk("p5_s3_in_en", 32'(IN_EN), 1);
        chk("p5_s3_done",  32'(DONE), 0);
        RST_N = 1'b0;
        tick();
        chk("p5_rst_busy",  32'(BUSY), 0);
        chk("p5_rst_in_en", 32'(IN_EN), 0);
        chk("p5_rst_valid", 32'(OUT_VALID), 0);
        chk("p5_rst_pend",  32'(PEND), 0);
        chk("p5_rst_done",  32'(DONE), 0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p5_post_done", 32'(DONE), 0);
            chk("p5_post_busy", 32'(BUSY), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
